// File: rtl/emif_access_ctrl.sv
// emif_access_ctrl: sequences asynchronous MCU EMIF accesses onto a double-buffered
// configuration bank. The MCU writes land in a shadow bank; a CTRL commit copies them
// to the active bank, which alone drives cfg_bus and encoder_mode.
module emif_access_ctrl #(
  parameter int unsigned SETTLE_CYC  = 5,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned NREG        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               emif_cs_n,
  input  logic               emif_we_n,
  input  logic               emif_oe_n,
  input  logic [12:0]        emif_addr,
  input  logic [15:0]        emif_data_in,
  output logic [15:0]        emif_data_out,
  output logic               emif_data_oe,
  output logic [4:0]         encoder_mode,
  output logic [NREG*16-1:0] cfg_bus,
  output logic               commit_pulse,
  output logic [2:0]         err_flags
);

  localparam int          CtrlIdx     = int'(NREG) - 1;
  localparam logic [12:0] CtrlAddr    = 13'(NREG - 1);
  localparam logic [3:0]  SettleLast  = 4'(SETTLE_CYC - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSettle, StWrite, StRead, StHold} state_e;

  // Synchroniser stages: strobes are {cs_n, we_n, oe_n}; bus is {addr, data}
  logic [2:0]  strb_q1, strb_q2;
  logic [28:0] bus_q1, bus_q2;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        is_wr_q, is_wr_d;
  logic        armed_q, armed_d;
  logic [12:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] shadow_q [NREG];
  logic [15:0] shadow_d [NREG];
  logic [15:0] active_q [NREG];
  logic [15:0] active_d [NREG];
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic        commit_q, commit_d;
  logic [2:0]  err_q, err_d;

  logic cs_s, we_s, oe_s, strb_s, released;
  assign cs_s     = strb_q2[2];
  assign we_s     = strb_q2[1];
  assign oe_s     = strb_q2[0];
  // High when the strobe that started this access has been released
  assign strb_s   = is_wr_q ? we_s : oe_s;
  assign released = cs_s | (we_s & oe_s);

  // Two-stage synchronisers for strobes, matching delay pipeline for addr/data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_q1 <= 3'b111;
      strb_q2 <= 3'b111;
      bus_q1  <= '0;
      bus_q2  <= '0;
    end else begin
      strb_q1 <= {emif_cs_n, emif_we_n, emif_oe_n};
      strb_q2 <= strb_q1;
      bus_q1  <= {emif_addr, emif_data_in};
      bus_q2  <= bus_q1;
    end
  end

  // Access sequencing, register bank updates and error bookkeeping
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    is_wr_d  = is_wr_q;
    armed_d  = armed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    shadow_d = shadow_q;
    active_d = active_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    commit_d = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        // A timed-out access leaves the FSM disarmed until the strobes are released
        if (released) armed_d = 1'b1;
        if (armed_q && !cs_s) begin
          if (!we_s && !oe_s) begin
            state_d  = StHold;
            tmo_d    = '0;
            is_wr_d  = 1'b1;
            err_d[1] = 1'b1;
          end else if (!we_s || !oe_s) begin
            state_d = StSettle;
            cnt_d   = '0;
            is_wr_d = !we_s;
          end
        end
      end
      StSettle: begin
        if (cs_s || strb_s) begin
          state_d = StIdle;
        end else if (cnt_q == SettleLast) begin
          addr_d  = bus_q2[28:16];
          data_d  = bus_q2[15:0];
          state_d = is_wr_q ? StWrite : StRead;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWrite: begin
        state_d = StHold;
        tmo_d   = '0;
        if (addr_q < CtrlAddr) begin
          for (int i = 0; i < CtrlIdx; i++) begin
            if (addr_q == 13'(i)) shadow_d[i] = data_q;
          end
        end else if (addr_q == CtrlAddr) begin
          if (data_q[0]) begin
            for (int i = 0; i < CtrlIdx; i++) active_d[i] = shadow_q[i];
            commit_d = 1'b1;
          end
        end else begin
          err_d[0] = 1'b1;
        end
        // Error clear wins over any error raised in the same cycle
        if (addr_q == CtrlAddr && data_q[1]) err_d = '0;
      end
      StRead: begin
        state_d = StHold;
        tmo_d   = '0;
        oe_d    = 1'b1;
        if (addr_q == CtrlAddr) begin
          dout_d = {13'd0, err_q};
        end else if (addr_q < CtrlAddr) begin
          for (int i = 0; i < CtrlIdx; i++) begin
            if (addr_q == 13'(i)) dout_d = shadow_q[i];
          end
        end else begin
          dout_d   = 16'hDEAD;
          err_d[0] = 1'b1;
        end
      end
      StHold: begin
        if (cs_s || strb_s) begin
          state_d = StIdle;
          oe_d    = 1'b0;
          armed_d = 1'b0;
        end else if (tmo_q == TimeoutLast) begin
          state_d  = StIdle;
          oe_d     = 1'b0;
          armed_d  = 1'b0;
          err_d[2] = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register bank flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tmo_q    <= '0;
      is_wr_q  <= 1'b0;
      armed_q  <= 1'b1;
      addr_q   <= '0;
      data_q   <= '0;
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      dout_q   <= '0;
      oe_q     <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      is_wr_q  <= is_wr_d;
      armed_q  <= armed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign emif_data_out = dout_q;
  assign emif_data_oe  = oe_q;
  assign commit_pulse  = commit_q;
  assign err_flags     = err_q;

  // The CTRL slot of the active bank is never loaded and reads as zero on cfg_bus
  for (genvar g = 0; g < int'(NREG); g++) begin : g_cfg
    assign cfg_bus[16*g +: 16] = active_q[g];
  end

  if (NREG > 3) begin : g_mode
    assign encoder_mode = active_q[3][4:0];
  end else begin : g_no_mode
    assign encoder_mode = 5'd0;
  end

endmodule

// File: doc/emif_access_ctrl.md
Name: emif_access_ctrl

Overview:
- Sequences MCU EMIF accesses to the FPGA configuration register bank.
- Synchronises the EMIF strobes, waits a settle window, then performs exactly one write or read per access.
- Register model is double-buffered: writes land in a shadow bank and are copied to the active bank only on a commit write.
- Sits between the EMIF pins and the encoder/config consumers, and drives encoder_mode plus the full active config bus.

Parameters:
- SETTLE_CYC, 5, clk cycles a strobe must stay asserted before address/data are used (1..15)
- TIMEOUT_CYC, 1000, max clk cycles in HOLD waiting for strobe release before error (1..65535)
- NREG, 8, number of 16-bit registers including CTRL; CTRL is index NREG-1 (2..16)

Ports:
- clk  in  1  system clock, 200 MHz
- rst  in  1  asynchronous, active-high reset
- emif_cs_n  in  1  EMIF chip select, async to clk
- emif_we_n  in  1  EMIF write strobe, async
- emif_oe_n  in  1  EMIF output-enable (read) strobe, async
- emif_addr  in  13  EMIF word address, async
- emif_data_in  in  16  EMIF write data, async
- emif_data_out  out  16  read-back data
- emif_data_oe  out  1  tristate enable for read-back
- encoder_mode  out  5  active[3][4:0]
- cfg_bus  out  NREG*16  active bank, reg i at bits [16i+15:16i]
- commit_pulse  out  1  one-cycle pulse when the active bank is updated
- err_flags  out  3  sticky errors: [0] address range, [1] both strobes asserted, [2] timeout

Behaviour:
- Reset: all outputs 0; shadow and active banks 0; FSM in IDLE; all sync flops reset to 1 for *_n inputs and 0 otherwise.
- Sync: cs_n, we_n and oe_n pass through 2-FF synchronisers. addr and data pass through a matching 2-stage pipeline, so all signals are aligned when used.
- FSM states: IDLE, SETTLE, WRITE, READ, HOLD.
- IDLE -> SETTLE when synced cs_n=0 and exactly one of we_n/oe_n is 0. Latch the access type and clear the settle counter.
- IDLE -> HOLD when cs_n=0 and both we_n and oe_n are 0. Set err_flags[1].
- SETTLE: counter increments each cycle the strobe stays low.
  - If cs_n or the latched strobe goes high before the counter reaches SETTLE_CYC: abort to IDLE with no register effect and no error.
  - When the counter reaches SETTLE_CYC: sample addr/data, then go to WRITE or READ.
- WRITE (1 cycle), then go to HOLD:
  - addr < NREG-1: shadow[addr] <= data.
  - addr == NREG-1 (CTRL), bit0 = 1: active <= shadow for all non-CTRL regs; commit_pulse asserts the next cycle.
  - CTRL bit1 = 1: err_flags <= 0. This clear takes priority over any error set in the same cycle.
  - addr >= NREG: no write; set err_flags[0].
- READ (1 cycle): register emif_data_out, assert emif_data_oe, then go to HOLD.
  - addr < NREG-1: returns shadow[addr].
  - CTRL returns {13'd0, err_flags}.
  - addr >= NREG returns 16'hDEAD and sets err_flags[0].
- HOLD: waits until synced cs_n=1, or the latched strobe returns high, then goes to IDLE.
  - emif_data_oe stays high through HOLD on reads and drops on the cycle IDLE is entered; emif_data_out holds its value.
  - Timeout counter increments each HOLD cycle. At TIMEOUT_CYC: set err_flags[2], drop emif_data_oe, go to IDLE.
  - On return to IDLE the FSM requires the strobes to be released first, so a stuck-low strobe cannot retrigger.
- Latency: write visible in shadow 2 (sync) + SETTLE_CYC + 1 clk after the strobe falls. A committed write is visible on cfg_bus one cycle after WRITE.
- encoder_mode and cfg_bus are registered from the active bank only, so they never glitch on shadow writes.
- Reset mid-access: immediate return to IDLE, outputs cleared, and emif_data_oe low asynchronously.

Test Plan:
- Write 16'h0012 to addr 3, SETTLE_CYC=5, strobe low for 12 clk -> shadow[3]=16'h0012; encoder_mode stays 0. Then write CTRL (addr 7) with 16'h0001 -> commit_pulse for 1 clk; encoder_mode=5'h12; cfg_bus[63:48]=16'h0012.
- Read addr 3 after the above -> emif_data_out=16'h0012, emif_data_oe high from READ until 1 cycle after oe_n release. Read addr 9 -> 16'hDEAD and err_flags=3'b001.
- we_n pulse of 3 clk (shorter than settle) to addr 2 with 16'hFFFF -> shadow[2] unchanged, err_flags unchanged, FSM back in IDLE.
- we_n and oe_n low together -> err_flags[1]=1 and no register change. Then write CTRL 16'h0002 -> err_flags=3'b000.
- Hold oe_n low for TIMEOUT_CYC+10 clk -> err_flags[2]=1 at TIMEOUT_CYC in HOLD; emif_data_oe low; no second access until oe_n goes high and then low again.
- Assert rst during SETTLE of a write to addr 1 -> all outputs 0 and shadow[1]=0; after release, a clean write to addr 1 succeeds.
